sap_ctrl_sequencer: RTL and testbench



---
 rtl/sap_ctrl_sequencer.sv | 115 +++++++++++
 tb/tb_sap_ctrl_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sap_ctrl_sequencer.sv
// SAP fetch/execute control sequencer: one-hot T-state ring plus opcode decode
// into the 12-bit control word, with free-run, single-step and halt support.
module sap_ctrl_sequencer #(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [3:0]  opcode,
    input  logic        step_mode,
    input  logic        step,
    output logic [11:0] ctrl,
    output logic [5:0]  t_state,
    output logic        halted
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    t_state_e    state_reg;
    t_state_e    state_next;
    logic        halted_reg;
    logic        halted_next;
    logic        step_q_reg;
    logic        advance;
    logic [11:0] ctrl_dec;

    // In single-step mode only the rising edge of the step level advances.
    assign advance = ena & ~halted_reg & (step_mode ? (step & ~step_q_reg) : 1'b1);

    always_comb begin
        state_next  = T1;
        halted_next = halted_reg;
        case (state_reg)
            T1: state_next = T2;
            T2: state_next = T3;
            T3: state_next = T4;
            T4: begin
                if (opcode == OP_HLT) begin
                    halted_next = 1'b1;
                    state_next  = T1;
                end else if (SHORT_CYCLE && opcode != OP_LDA &&
                             opcode != OP_ADD && opcode != OP_SUB) begin
                    state_next = T1;
                end else begin
                    state_next = T5;
                end
            end
            T5: state_next = (SHORT_CYCLE && opcode == OP_LDA) ? T1 : T6;
            T6: state_next = T1;
            // Any non-one-hot value (e.g. an upset) falls back to T1.
            default: state_next = T1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= T1;
            halted_reg <= 1'b0;
            step_q_reg <= 1'b0;
        end else if (ena) begin
            step_q_reg <= step;
            if (advance) begin
                state_reg  <= state_next;
                halted_reg <= halted_next;
            end
        end
    end

    always_comb begin
        ctrl_dec = 12'h000;
        case (state_reg)
            T1: ctrl_dec = 12'h600;
            T2: ctrl_dec = 12'h800;
            T3: ctrl_dec = 12'h180;
            T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB)
                    ctrl_dec = 12'h240;
                else if (opcode == OP_OUT)
                    ctrl_dec = 12'h011;
            end
            T5: begin
                if (opcode == OP_LDA)
                    ctrl_dec = 12'h120;
                else if (opcode == OP_ADD || opcode == OP_SUB)
                    ctrl_dec = 12'h102;
            end
            T6: begin
                if (opcode == OP_ADD)
                    ctrl_dec = 12'h024;
                else if (opcode == OP_SUB)
                    ctrl_dec = 12'h02C;
            end
            default: ctrl_dec = 12'h000;
        endcase
    end

    // Strobes are gated off during reset and after HLT.
    assign ctrl    = (rst_n && !halted_reg) ? ctrl_dec : 12'h000;
    assign t_state = state_reg;
    assign halted  = halted_reg;

endmodule

// File: tb/tb_sap_ctrl_sequencer.sv
// Directed bench for sap_ctrl_sequencer; a long-cycle and a short-cycle instance
// share the same stimulus.
module tb_sap_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  opcode;
    logic        step_mode;
    logic        step;
    logic [11:0] ctrl_l, ctrl_s;
    logic [5:0]  t_state_l, t_state_s;
    logic        halted_l, halted_s;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sap_ctrl_sequencer #(.SHORT_CYCLE(1'b0)) dut_long (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode),
        .step_mode(step_mode), .step(step),
        .ctrl(ctrl_l), .t_state(t_state_l), .halted(halted_l)
    );

    sap_ctrl_sequencer #(.SHORT_CYCLE(1'b1)) dut_short (
        .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode),
        .step_mode(step_mode), .step(step),
        .ctrl(ctrl_s), .t_state(t_state_s), .halted(halted_s)
    );

    task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        compared++;
        if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: 0x%03h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    logic [5:0]  lda_t  [6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
    logic [11:0] lda_c  [6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
    logic [11:0] sub_c  [6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h102, 12'h02C};
    logic [5:0]  out_t  [5] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h01};
    logic [5:0]  step_t [3] = '{6'h02, 6'h04, 6'h08};

    initial begin
        rst_n = 1'b0; ena = 1'b1; opcode = 4'h0; step_mode = 1'b0; step = 1'b0;
        #1;
        // Reset state: ctrl forced low while reset is held
        tick();
        tick();
        check_val("rst_ctrl", ctrl_l, 12'h000);
        check_val("rst_t", {6'b0, t_state_l}, 12'h001);
        check_val("rst_halted", {11'b0, halted_l}, 12'h000);
        rst_n = 1'b1;
        #1;

        // LDA free-run
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("lda_t%0d", i + 1), {6'b0, t_state_l}, {6'b0, lda_t[i]});
            check_val($sformatf("lda_c%0d", i + 1), ctrl_l, lda_c[i]);
            tick();
        end
        check_val("lda_wrap", {6'b0, t_state_l}, 12'h001);

        // SUB free-run
        opcode = 4'h2;
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("sub_c%0d", i + 1), ctrl_l, sub_c[i]);
            tick();
        end
        check_val("sub_wrap", {6'b0, t_state_l}, 12'h001);

        // HLT
        opcode = 4'hF;
        tick(); tick(); tick();
        check_val("hlt_t4", {6'b0, t_state_l}, 12'h008);
        check_val("hlt_t4_ctrl", ctrl_l, 12'h000);
        tick();
        check_val("hlt_halted", {11'b0, halted_l}, 12'h001);
        check_val("hlt_ctrl", ctrl_l, 12'h000);
        check_val("hlt_t", {6'b0, t_state_l}, 12'h001);
        for (int i = 0; i < 20; i++) tick();
        check_val("hlt_hold_t", {6'b0, t_state_l}, 12'h001);
        check_val("hlt_hold_halted", {11'b0, halted_l}, 12'h001);
        check_val("hlt_hold_ctrl", ctrl_l, 12'h000);
        rst_n = 1'b0;
        tick();
        check_val("hlt_clr", {11'b0, halted_l}, 12'h000);
        rst_n = 1'b1;
        #1;
        check_val("hlt_clr_ctrl", ctrl_l, 12'h600);

        // Single-step with step held high several cycles
        opcode = 4'h0;
        step_mode = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step = 1'b1;
            for (int i = 0; i < 5; i++) tick();
            check_val($sformatf("step_hi%0d", g), {6'b0, t_state_l}, {6'b0, step_t[g]});
            step = 1'b0;
            for (int i = 0; i < 3; i++) tick();
            check_val($sformatf("step_lo%0d", g), {6'b0, t_state_l}, {6'b0, step_t[g]});
        end
        step_mode = 1'b0;

        // Short cycle OUT
        do_reset();
        opcode = 4'hE;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("out_short_t%0d", i), {6'b0, t_state_s}, {6'b0, out_t[i]});
            if (i == 3) check_val("out_short_c4", ctrl_s, 12'h011);
            tick();
        end
        check_val("out_long_t", {6'b0, t_state_l}, 12'h020);
        check_val("out_long_c", ctrl_l, 12'h000);

        // Reset in T5 of ADD, then ena freeze
        do_reset();
        opcode = 4'h1;
        for (int i = 0; i < 4; i++) tick();
        check_val("add_c5", ctrl_l, 12'h102);
        rst_n = 1'b0;
        #1;
        check_val("add_rst_ctrl", ctrl_l, 12'h000);
        tick();
        check_val("add_rst_ctrl2", ctrl_l, 12'h000);
        check_val("add_rst_t", {6'b0, t_state_l}, 12'h001);
        rst_n = 1'b1;
        #1;
        check_val("add_rel_ctrl", ctrl_l, 12'h600);
        check_val("add_rel_t", {6'b0, t_state_l}, 12'h001);
        tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("ena_t%0d", i), {6'b0, t_state_l}, 12'h002);
            check_val($sformatf("ena_c%0d", i), ctrl_l, 12'h800);
        end
        ena = 1'b1;
        tick();
        check_val("ena_resume", {6'b0, t_state_l}, 12'h004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
